barrett_param_gen: RTL

//  Precomputes Barrett constants for a modulus q: k = bit length of q, mu = floor(2^(2k)/q).

---
 rtl/barrett_param_gen_pkg.sv | 8 +
 rtl/barrett_param_gen_msb_index.sv | 14 +
 rtl/barrett_param_gen.sv | 111 +++++++++++
 3 files changed

// File: rtl/barrett_param_gen_pkg.sv
// barrett_pkg: shared widths, legal-k limit and FSM state type for the Barrett parameter generator.
package barrett_pkg;
    localparam int Q_W = 64;
    localparam int MU_W = 31;
    localparam int K_W = 8;
    localparam int MAX_K = MU_W - 2;
    typedef enum logic [1:0] {IDLE, NORM, DIV, DONE} state_t;
endpackage

// File: rtl/barrett_param_gen_msb_index.sv
// msb_index: combinational leading-one encoder returning the bit length of q (0 for q=0).
module msb_index #(
    parameter int Q_W = 64,
    parameter int K_W = 8
) (
    input  logic [Q_W-1:0] q,
    output logic [K_W-1:0] len
);
    always_comb begin
        len = '0;
        for (int i = 0; i < Q_W; i++)
            if (q[i]) len = K_W'(i + 1);
    end
endmodule

// File: rtl/barrett_param_gen.sv
// barrett_param_gen: computes k = bitlen(q) and mu = floor(2^(2k)/q) with a bit-serial restoring divider.
// Optional remainder output port enabled by BARRETT_PARAM_REM_EN.
module barrett_param_gen
    import barrett_pkg::*;
#(
    parameter int Q_W = barrett_pkg::Q_W,
    parameter int MU_W = barrett_pkg::MU_W,
    parameter int K_W = barrett_pkg::K_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [Q_W-1:0]  q_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [MU_W-1:0] mu,
    output logic [K_W-1:0]  k,
    output logic            err
`ifdef BARRETT_PARAM_REM_EN
    ,
    output logic [Q_W-1:0]  rem
`endif
);
    state_t          state;
    logic [Q_W-1:0]  qr;
    logic [Q_W:0]    r;
    logic [MU_W-1:0] quo;
    logic [K_W-1:0]  cnt;
    logic [K_W-1:0]  kr;
    logic [K_W-1:0]  bl;
    logic [Q_W:0]    sh;
    logic [Q_W:0]    rn;
    logic [MU_W-1:0] qn;
    logic            take;

    msb_index #(.Q_W(Q_W), .K_W(K_W)) u_msb (.q(qr), .len(bl));

    // The dividend 2^(2k) has a single one bit, at the first processed index.
    always_comb begin
        sh = {r[Q_W-1:0], cnt == {kr[K_W-2:0], 1'b0}};
        take = sh >= {1'b0, qr};
        rn = take ? sh - {1'b0, qr} : sh;
        qn = {quo[MU_W-2:0], take};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
            mu <= '0;
            k <= '0;
            err <= 1'b0;
            qr <= '0;
            r <= '0;
            quo <= '0;
            cnt <= '0;
            kr <= '0;
`ifdef BARRETT_PARAM_REM_EN
            rem <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    qr <= q_in;
                    in_ready <= 1'b0;
                    state <= NORM;
                end
                NORM: if (bl == '0 || bl > K_W'(MU_W - 2)) begin
                    err <= 1'b1;
                    mu <= '0;
                    k <= '0;
`ifdef BARRETT_PARAM_REM_EN
                    rem <= '0;
`endif
                    out_valid <= 1'b1;
                    state <= DONE;
                end else begin
                    kr <= bl;
                    r <= '0;
                    quo <= '0;
                    cnt <= {bl[K_W-2:0], 1'b0};
                    state <= DIV;
                end
                DIV: begin
                    r <= rn;
                    quo <= qn;
                    if (cnt == '0) begin
                        mu <= qn;
                        k <= kr;
                        err <= 1'b0;
`ifdef BARRETT_PARAM_REM_EN
                        rem <= rn[Q_W-1:0];
`endif
                        out_valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
